// File: rtl/twos_dec_pkg.sv
// twos_dec_pkg: state encoding and width helper shared by the two's complement
// to sign-magnitude serial decoder.
package twos_dec_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    DONE_S = ST_DONE
  } state_t;
  function automatic int clog2(input int v);
    clog2 = 0;
    for (int i = v - 1; i > 0; i = i >> 1) clog2 = clog2 + 1;
  endfunction
endpackage

// File: rtl/twos_neg_bit.sv
// twos_neg_bit: one step of the serial negate rule (copy up to and including the
// first 1, invert every bit after it) applied only to negative operands.
module twos_neg_bit (
  input  logic b,
  input  logic sgn,
  input  logic seen_one,
  output logic r,
  output logic seen_one_nxt
);
  assign r            = (sgn & seen_one) ? ~b : b;
  assign seen_one_nxt = seen_one | b;
endmodule

// File: rtl/twos_to_signmag_serial.sv
// twos_to_signmag_serial: bit-serial two's complement to sign-magnitude decoder.
// Define TWOS_DEC_FAST_POS_EN to let non-negative operands bypass the serial walk.
module twos_to_signmag_serial
  import twos_dec_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             ovf
);
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_nxt;
  logic [WIDTH-1:0] sh, a_cap;
  logic [CW-1:0] cnt;
  logic sgn, seen_one, r, seen_one_nxt, fast;
`ifdef TWOS_DEC_FAST_POS_EN
  assign fast = ~a[WIDTH-1];
`else
  assign fast = 1'b0;
`endif
  twos_neg_bit u_neg (
    .b            (sh[0]),
    .sgn          (sgn),
    .seen_one     (seen_one),
    .r            (r),
    .seen_one_nxt (seen_one_nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (fast ? DONE_S : SHIFT) : IDLE;
      SHIFT:   state_nxt = (cnt == LAST) ? DONE_S : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end
  assign busy = (state != IDLE);
  // sh doubles as the accumulator: operand bits leave at the LSB while result bits
  // enter at the MSB, so after WIDTH shifts it holds the magnitude.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh       <= '0;
      a_cap    <= '0;
      cnt      <= '0;
      sgn      <= 1'b0;
      seen_one <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      mag      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        sh       <= a;
        a_cap    <= a;
        sgn      <= a[WIDTH-1];
        cnt      <= '0;
        seen_one <= 1'b0;
        if (fast) begin
          mag  <= a;
          sign <= 1'b0;
          ovf  <= 1'b0;
          done <= 1'b1;
        end
      end else if (state == SHIFT) begin
        sh       <= {r, sh[WIDTH-1:1]};
        seen_one <= seen_one_nxt;
        if (cnt == LAST) begin
          mag  <= {r, sh[WIDTH-1:1]};
          sign <= sgn;
          ovf  <= sgn & (a_cap == MOST_NEG);
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// tb_twos_to_signmag_serial: directed and random checks of the serial decoder
// against an arithmetic model of sign-magnitude conversion (WIDTH=4).
module tb_twos_to_signmag_serial;
  logic clk, rst_n, start, busy, done, sign, ovf;
  logic [3:0] a, mag;
  int checks = 0;
  int errors = 0;
  twos_to_signmag_serial #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .mag   (mag),
    .ovf   (ovf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [3:0] v, output logic s, output logic [3:0] m, output logic o);
    int x;
    x = $signed(v);
    s = x < 0;
    m = 4'(s ? -x : x);
    o = (x == -8);
  endfunction
  task automatic run(input logic [3:0] v, input string tag);
    int n;
    logic es, eo;
    logic [3:0] em;
    model(v, es, em, eo);
    a = v;
    start = 1'b1;
    step();
    start = 1'b0;
    a = 4'($urandom);
    n = 0;
    while (!done && n < 20) begin
      check({tag, " busy"}, busy, 1);
      step();
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " busy@done"}, busy, 1);
    check({tag, " sign"}, sign, es);
    check({tag, " mag"}, mag, em);
    check({tag, " ovf"}, ovf, eo);
    step();
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle"}, busy, 0);
    check({tag, " mag hold"}, mag, em);
  endtask
  initial begin
    int n, pulses;
    rst_n = 1'b0;
    start = 1'b0;
    a = 4'd0;
    step();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sign", sign, 0);
    check("rst mag", mag, 0);
    check("rst ovf", ovf, 0);
    rst_n = 1'b1;
    step();
    run(4'b0011, "pos3");
    run(4'b1101, "neg3");
    run(4'b1111, "neg1");
    run(4'b1000, "mostneg");
    run(4'b0000, "zero");
    // START during SHIFT must be dropped, not queued
    a = 4'b1010;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 4'b0111;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 2;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("ign latency", n, 4);
    check("ign sign", sign, 1);
    check("ign mag", mag, 4'b0110);
    check("ign ovf", ovf, 0);
    pulses = 0;
    repeat (8) begin
      step();
      pulses += int'(done);
    end
    check("ign extra done", pulses, 0);
    check("ign idle", busy, 0);
    // async reset mid-conversion
    a = 4'b1011;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sign", sign, 0);
    check("abort mag", mag, 0);
    check("abort ovf", ovf, 0);
    pulses = 0;
    repeat (3) begin
      step();
      pulses += int'(done);
    end
    check("abort no done", pulses, 0);
    rst_n = 1'b1;
    step();
    run(4'b0101, "after abort");
    for (int i = 0; i < 16; i++) run(4'(i), $sformatf("sweep%0d", i));
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) step();
      run(4'($urandom), $sformatf("rand%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
